// File: rtl/calc_sequencer.sv
// calc_sequencer: command FIFO plus a four-state sequencer that drives the
// simple_calculator ports (ALU + 8x8 register file). Each command runs one
// ALU operation with optional writeback. The written register is then read
// back and returned as a response over a valid/ready handshake.
// Optional feature macro: CALC_SEQ_STATUS_EN adds sticky status flags and a
// count of completed responses.
module calc_sequencer #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_op,
   input  logic       cmd_sel,
   input  logic [2:0] cmd_rw,
   input  logic [2:0] cmd_rx,
   input  logic [2:0] cmd_ry,
   input  logic [7:0] cmd_imm,
   input  logic       cmd_wb,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_carry,
   output logic       rsp_err,
   output logic       calc_wen,
   output logic [2:0] calc_rw,
   output logic [2:0] calc_rx,
   output logic [2:0] calc_ry,
   output logic       calc_sel,
   output logic [3:0] calc_ctrl,
   output logic [7:0] calc_datain,
   input  logic [7:0] calc_busy,
   input  logic       calc_carry
`ifdef CALC_SEQ_STATUS_EN
   ,
   input  logic       stat_clr,
   output logic       stat_carry,
   output logic       stat_err,
   output logic [7:0] stat_cnt
`endif
);

   typedef struct packed {
      logic [3:0] op;
      logic       sel;
      logic [2:0] rw;
      logic [2:0] rx;
      logic [2:0] ry;
      logic [7:0] imm;
      logic       wb;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, EXEC, READ, RESP} state_t;

   // Highest Ctrl code the ALU accepts as a legal operation.
   localparam logic [3:0]  LAST_LEGAL_OP = 4'd12;
   localparam logic [AW:0] FULL_CNT      = (AW+1)'(DEPTH);

   cmd_t          fifo_mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   state_t        state_q, state_d;
   cmd_t          cur_q, cur_d;
   logic [7:0]    rsp_data_q, rsp_data_d;
   logic          rsp_carry_q, rsp_carry_d;
   logic          rsp_err_q, rsp_err_d;

   logic full, push, pop, legal, wen_exec;
   cmd_t cmd_in;

   assign cmd_in = '{op: cmd_op, sel: cmd_sel, rw: cmd_rw, rx: cmd_rx,
                     ry: cmd_ry, imm: cmd_imm, wb: cmd_wb};

   // FIFO occupancy and pointer arithmetic; full blocks pushes even if a pop happens
   always_comb begin
      full     = (count_q == FULL_CNT);
      push     = cmd_valid && !full;
      pop      = (state_q == IDLE) && (count_q != '0);
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
   end

   // Command storage; no reset needed since occupancy is tracked by count_q
   always_ff @(posedge Clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= cmd_in;
      end
   end

   // Next-state, current command and response capture
   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      rsp_data_d  = rsp_data_q;
      rsp_carry_d = rsp_carry_q;
      rsp_err_d   = rsp_err_q;
      legal       = (cur_q.op <= LAST_LEGAL_OP);
      wen_exec    = cur_q.wb && legal;
      case (state_q)
         IDLE: begin
            if (pop) begin
               cur_d       = fifo_mem[rd_ptr_q];
               rsp_data_d  = 8'h00;
               rsp_carry_d = 1'b0;
               rsp_err_d   = 1'b0;
               state_d     = EXEC;
            end
         end
         EXEC: begin
            rsp_carry_d = legal ? calc_carry : 1'b0;
            rsp_err_d   = !legal;
            rsp_data_d  = 8'h00;
            state_d     = wen_exec ? READ : RESP;
         end
         READ: begin
            rsp_data_d = calc_busy;
            state_d    = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= IDLE;
         cur_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rsp_data_q  <= 8'h00;
         rsp_carry_q <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rsp_data_q  <= rsp_data_d;
         rsp_carry_q <= rsp_carry_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Calculator drive; write enable and response valid are masked during reset
   // so a command interrupted mid-EXEC never writes and never responds
   always_comb begin
      cmd_ready   = !full;
      calc_wen    = (state_q == EXEC) && wen_exec && !Rst;
      calc_rw     = cur_q.rw;
      calc_rx     = cur_q.rx;
      calc_ry     = (state_q == READ) ? cur_q.rw : cur_q.ry;
      calc_sel    = cur_q.sel;
      calc_ctrl   = cur_q.op;
      calc_datain = cur_q.imm;
      rsp_valid   = (state_q == RESP) && !Rst;
      rsp_data    = rsp_data_q;
      rsp_carry   = rsp_carry_q;
      rsp_err     = rsp_err_q;
   end

`ifdef CALC_SEQ_STATUS_EN
   logic       stat_carry_q, stat_carry_d;
   logic       stat_err_q, stat_err_d;
   logic [7:0] stat_cnt_q, stat_cnt_d;

   // Sticky flags and response count; a clear beats a same-cycle handshake
   always_comb begin
      stat_carry_d = stat_carry_q;
      stat_err_d   = stat_err_q;
      stat_cnt_d   = stat_cnt_q;
      if (stat_clr) begin
         stat_carry_d = 1'b0;
         stat_err_d   = 1'b0;
         stat_cnt_d   = 8'h00;
      end else if (rsp_valid && rsp_ready) begin
         stat_carry_d = stat_carry_q | rsp_carry_q;
         stat_err_d   = stat_err_q | rsp_err_q;
         stat_cnt_d   = stat_cnt_q + 8'd1;
      end
   end

   // Status registers
   always_ff @(posedge Clk) begin
      if (Rst) begin
         stat_carry_q <= 1'b0;
         stat_err_q   <= 1'b0;
         stat_cnt_q   <= 8'h00;
      end else begin
         stat_carry_q <= stat_carry_d;
         stat_err_q   <= stat_err_d;
         stat_cnt_q   <= stat_cnt_d;
      end
   end

   assign stat_carry = stat_carry_q;
   assign stat_err   = stat_err_q;
   assign stat_cnt   = stat_cnt_q;
`endif

endmodule

// File: tb/tb_calc_sequencer.sv
// Testbench for calc_sequencer. A behavioural simple_calculator (ALU plus
// register file) drives calc_busy/calc_carry. Expected responses come from an
// in-order command queue and a shadow register array.
module tb_calc_sequencer;

   logic       Clk = 1'b0;
   logic       Rst;
   logic       cmd_valid, cmd_ready;
   logic [3:0] cmd_op;
   logic       cmd_sel;
   logic [2:0] cmd_rw, cmd_rx, cmd_ry;
   logic [7:0] cmd_imm;
   logic       cmd_wb;
   logic       rsp_valid, rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_carry, rsp_err;
   logic       calc_wen;
   logic [2:0] calc_rw, calc_rx, calc_ry;
   logic       calc_sel;
   logic [3:0] calc_ctrl;
   logic [7:0] calc_datain, calc_busy;
   logic       calc_carry;
`ifdef CALC_SEQ_STATUS_EN
   logic       stat_clr, stat_carry, stat_err;
   logic [7:0] stat_cnt;
`endif

   always #5 Clk = ~Clk;

   calc_sequencer #(.DEPTH(4), .AW(2)) dut (
      .Clk(Clk), .Rst(Rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_sel(cmd_sel), .cmd_rw(cmd_rw), .cmd_rx(cmd_rx), .cmd_ry(cmd_ry),
      .cmd_imm(cmd_imm), .cmd_wb(cmd_wb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_carry(rsp_carry), .rsp_err(rsp_err),
      .calc_wen(calc_wen), .calc_rw(calc_rw), .calc_rx(calc_rx),
      .calc_ry(calc_ry), .calc_sel(calc_sel), .calc_ctrl(calc_ctrl),
      .calc_datain(calc_datain), .calc_busy(calc_busy), .calc_carry(calc_carry)
`ifdef CALC_SEQ_STATUS_EN
      , .stat_clr(stat_clr), .stat_carry(stat_carry), .stat_err(stat_err),
      .stat_cnt(stat_cnt)
`endif
   );

   // ALU behaviour of the calculator: returns {carry, result}
   function automatic logic [8:0] alu(input logic [3:0] op, input logic [7:0] x,
                                      input logic [7:0] y);
      case (op)
         4'd0:    return {1'b0, x} + {1'b0, y};
         4'd1:    return {1'b0, x} - {1'b0, y};
         4'd2:    return {1'b0, x & y};
         4'd3:    return {1'b0, x | y};
         4'd4:    return {1'b0, x ^ y};
         4'd5:    return {1'b0, ~x};
         4'd6:    return {x, 1'b0};
         4'd7:    return {x[0], 1'b0, x[7:1]};
         4'd8:    return {1'b0, x};
         4'd9:    return {1'b0, y};
         4'd10:   return {1'b0, x} + 9'd1;
         4'd11:   return {1'b0, x} - 9'd1;
         4'd12:   return {1'b0, x} + {1'b0, y} + 9'd1;
         default: return 9'd0;
      endcase
   endfunction

   // Calculator environment: register file (r0 reads as zero) + ALU
   logic [7:0] env_r [8];
   logic       env_clr;
   logic [7:0] env_x, env_res;
   always_comb begin
      env_x     = calc_sel ? env_r[calc_rx] : calc_datain;
      calc_busy = env_r[calc_ry];
      {calc_carry, env_res} = alu(calc_ctrl, env_x, env_r[calc_ry]);
   end
   always @(posedge Clk) begin
      if (env_clr) begin
         for (int i = 0; i < 8; i++) env_r[i] <= 8'h00;
      end else if (calc_wen) begin
         env_r[calc_rw] <= (calc_rw == 3'd0) ? 8'h00 : env_res;
      end
   end

   // Counts any cycle where an illegal op is written back
   int bad_wen_cnt = 0;
   always @(negedge Clk) begin
      if (calc_wen && calc_ctrl > 4'd12) bad_wen_cnt <= bad_wen_cnt + 1;
   end

   typedef struct {
      logic [3:0] op;
      logic       sel;
      logic [2:0] rw, rx, ry;
      logic [7:0] imm;
      logic       wb;
   } tcmd_t;

   tcmd_t      pend_q[$];
   logic [7:0] sh [8];
   int         n_assert = 0;
   int         n_fail   = 0;
   logic [7:0] last_data;
   logic       last_carry, last_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: what the command should return, from the shadow register state
   task automatic model_exec(input tcmd_t c, output logic [7:0] d, output logic cy,
                             output logic er);
      logic [8:0] r;
      logic [7:0] x;
      x  = c.sel ? sh[c.rx] : c.imm;
      r  = alu(c.op, x, sh[c.ry]);
      d  = 8'h00;
      cy = 1'b0;
      er = 1'b0;
      if (c.op > 4'd12) begin
         er = 1'b1;
      end else begin
         cy = r[8];
         if (c.wb) begin
            if (c.rw != 3'd0) sh[c.rw] = r[7:0];
            d = sh[c.rw];
         end
      end
   endtask

   task automatic push_cmd(input tcmd_t c);
      logic rb;
      logic ok;
      ok        = 1'b0;
      cmd_op    = c.op;  cmd_sel = c.sel; cmd_rw = c.rw; cmd_rx = c.rx;
      cmd_ry    = c.ry;  cmd_imm = c.imm; cmd_wb = c.wb;
      cmd_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         rb = cmd_ready;
         @(posedge Clk); #1;
         if (rb) begin ok = 1'b1; break; end
      end
      cmd_valid = 1'b0;
      check("push_accept", 32'(ok), 32'd1);
      if (ok) pend_q.push_back(c);
      $display("push op=%0h sel=%0b rw=%0d rx=%0d ry=%0d imm=%02h wb=%0b",
               c.op, c.sel, c.rw, c.rx, c.ry, c.imm, c.wb);
   endtask

   // Waits for a response, optionally holds it for a few cycles, then accepts it
   task automatic get_rsp(input int hold, output int lat);
      tcmd_t      c;
      logic [7:0] ed;
      logic       ec, ee;
      lat = 0;
      while (!rsp_valid && lat < 50) begin
         @(posedge Clk); #1; lat++;
      end
      check("rsp_timeout", 32'(rsp_valid), 32'd1);
      if (rsp_valid) begin
         last_data  = rsp_data;
         last_carry = rsp_carry;
         last_err   = rsp_err;
         for (int h = 0; h < hold; h++) begin
            @(posedge Clk); #1;
            check("rsp_hold", {22'd0, rsp_valid, rsp_carry, rsp_err, rsp_data},
                  {22'd0, 1'b1, last_carry, last_err, last_data});
         end
         rsp_ready = 1'b1;
         @(posedge Clk); #1;
         rsp_ready = 1'b0;
         check("rsp_expected", 32'(pend_q.size() > 0), 32'd1);
         if (pend_q.size() > 0) begin
            c = pend_q.pop_front();
            model_exec(c, ed, ec, ee);
            check("rsp_data", 32'(last_data), 32'(ed));
            check("rsp_carry", 32'(last_carry), 32'(ec));
            check("rsp_err", 32'(last_err), 32'(ee));
         end
         $display("rsp data=%02h carry=%0b err=%0b lat=%0d", last_data, last_carry,
                  last_err, lat);
      end
   endtask

   function automatic tcmd_t mk(input logic [3:0] op, input logic sel, input logic [2:0] rw,
                                input logic [2:0] rx, input logic [2:0] ry,
                                input logic [7:0] imm, input logic wb);
      tcmd_t c;
      c.op = op; c.sel = sel; c.rw = rw; c.rx = rx; c.ry = ry; c.imm = imm; c.wb = wb;
      return c;
   endfunction

   initial begin
      tcmd_t c;
      int    lat;
      int    viol;
      Rst = 1'b1; env_clr = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_op = '0; cmd_sel = 1'b0; cmd_rw = '0; cmd_rx = '0; cmd_ry = '0;
      cmd_imm = '0; cmd_wb = 1'b0;
`ifdef CALC_SEQ_STATUS_EN
      stat_clr = 1'b0;
`endif
      for (int i = 0; i < 8; i++) sh[i] = 8'h00;
      repeat (3) @(posedge Clk);
      #1;
      Rst = 1'b0; env_clr = 1'b0;

      // Reset state
      check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_calc_wen", 32'(calc_wen), 32'd0);
      check("reset_rsp", {23'd0, rsp_carry, rsp_err, rsp_data}, 32'd0);
      check("reset_calc", {13'd0, calc_rw, calc_rx, calc_ry, calc_sel, calc_ctrl, calc_datain},
            32'd0);

      // 1: immediate writeback, latency N+3
      push_cmd(mk(4'd0, 1'b0, 3'd1, 3'd0, 3'd0, 8'h05, 1'b1));
      get_rsp(0, lat);
      check("t1_latency", 32'(lat), 32'd3);
      check("t1_data", 32'(last_data), 32'h05);

      // 2: r1=F0, r2=20, r3 = r1 + r2 with carry out
      push_cmd(mk(4'd0, 1'b0, 3'd1, 3'd0, 3'd0, 8'hF0, 1'b1));
      get_rsp(0, lat);
      push_cmd(mk(4'd0, 1'b0, 3'd2, 3'd0, 3'd0, 8'h20, 1'b1));
      get_rsp(0, lat);
      push_cmd(mk(4'd0, 1'b1, 3'd3, 3'd1, 3'd2, 8'h00, 1'b1));
      get_rsp(0, lat);
      check("t2_data", 32'(last_data), 32'h10);
      check("t2_carry", 32'(last_carry), 32'd1);

      // 3: fill while responses are stalled, then drain in order
      for (int i = 0; i < 5; i++) begin
         c = mk(4'($urandom_range(12, 0)), 1'($urandom), 3'(4 + $urandom_range(3, 0)),
                3'($urandom), 3'($urandom), 8'($urandom), 1'($urandom));
         push_cmd(c);
      end
      check("t3_full_ready", 32'(cmd_ready), 32'd0);
      get_rsp(2, lat);
      for (int i = 0; i < 4; i++) get_rsp(0, lat);
      check("t3_drained", 32'(pend_q.size()), 32'd0);
      check("t3_ready_back", 32'(cmd_ready), 32'd1);

      // 4: illegal op with writeback requested
      push_cmd(mk(4'b1110, 1'b0, 3'd3, 3'd0, 3'd0, 8'h55, 1'b1));
      get_rsp(0, lat);
      check("t4_err", 32'(last_err), 32'd1);
      check("t4_data", 32'(last_data), 32'd0);
      check("t4_carry", 32'(last_carry), 32'd0);
      check("t4_r3_kept", 32'(env_r[3]), 32'h10);
      check("t4_no_wen", 32'(bad_wen_cnt), 32'd0);

      // 5: reset while a writeback command is in EXEC
      push_cmd(mk(4'd0, 1'b0, 3'd5, 3'd0, 3'd0, 8'h77, 1'b1));
      lat = 0;
      while (!calc_wen && lat < 10) begin
         @(posedge Clk); #1; lat++;
      end
      check("t5_reach_exec", 32'(calc_wen), 32'd1);
      Rst = 1'b1;
      #1;
      check("t5_wen_in_reset", 32'(calc_wen), 32'd0);
      @(posedge Clk); #1;
      Rst = 1'b0;
      void'(pend_q.pop_back());
      check("t5_cmd_ready", 32'(cmd_ready), 32'd1);
      check("t5_r5_unwritten", 32'(env_r[5]), 32'(sh[5]));
      viol = 0;
      for (int i = 0; i < 5; i++) begin
         if (rsp_valid || calc_wen) viol++;
         @(posedge Clk); #1;
      end
      check("t5_quiet_after_reset", 32'(viol), 32'd0);

`ifdef CALC_SEQ_STATUS_EN
      // 6: sticky status after a carry response and an error response
      stat_clr = 1'b1;
      @(posedge Clk); #1;
      stat_clr = 1'b0;
      push_cmd(mk(4'd0, 1'b1, 3'd3, 3'd1, 3'd2, 8'h00, 1'b1));
      get_rsp(0, lat);
      push_cmd(mk(4'b1110, 1'b0, 3'd3, 3'd0, 3'd0, 8'h55, 1'b1));
      get_rsp(0, lat);
      check("t6_stat", {22'd0, stat_carry, stat_err, stat_cnt}, {22'd0, 1'b1, 1'b1, 8'd2});
      stat_clr = 1'b1;
      @(posedge Clk); #1;
      stat_clr = 1'b0;
      check("t6_stat_clr", {22'd0, stat_carry, stat_err, stat_cnt}, 32'd0);
`endif

      // Random single commands: response and latency vs reference
      for (int i = 0; i < 30; i++) begin
         c = mk(4'($urandom), 1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                8'($urandom), 1'($urandom));
         push_cmd(c);
         get_rsp(0, lat);
         check("rnd_latency", 32'(lat), (c.wb && c.op <= 4'd12) ? 32'd3 : 32'd2);
      end

      // Random bursts with queued commands
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 3; i++) begin
            c = mk(4'($urandom), 1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                   8'($urandom), 1'($urandom));
            push_cmd(c);
         end
         for (int i = 0; i < 3; i++) get_rsp($urandom_range(1, 0), lat);
      end
      check("final_no_illegal_wen", 32'(bad_wen_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
